// File: rtl/lsu_output_buffer.sv
// LSU output-peripheral register bank at 0x7000-0x703F.
// Byte-lane stores drive LEDs, seven-segment digits and LCD word.
module lsu_output_buffer #(
  parameter int LEDR_W = 17,
  parameter int LEDG_W = 8,
  parameter int LCD_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [15:0]       i_lsu_addr,
  input  logic [31:0]       i_st_data,
  input  logic              i_lsu_wren,
  input  logic [1:0]        i_st_size,
  output logic [31:0]       o_ld_data,
  output logic [LEDR_W-1:0] o_io_ledr,
  output logic [LEDG_W-1:0] o_io_ledg,
  output logic [6:0]        o_io_hex0,
  output logic [6:0]        o_io_hex1,
  output logic [6:0]        o_io_hex2,
  output logic [6:0]        o_io_hex3,
  output logic [6:0]        o_io_hex4,
  output logic [6:0]        o_io_hex5,
  output logic [6:0]        o_io_hex6,
  output logic [6:0]        o_io_hex7,
  output logic [LCD_W-1:0]  o_io_lcd
);

  localparam logic [31:0] LEDR_M =
    32'((64'd1 << LEDR_W) - 64'd1);
  localparam logic [31:0] LEDG_M =
    32'((64'd1 << LEDG_W) - 64'd1);
  localparam logic [31:0] LCD_M =
    32'((64'd1 << LCD_W) - 64'd1);
  localparam logic [31:0] HEX_M = 32'h7F7F_7F7F;

  logic        in_win;
  logic [3:0]  word;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] bm;
  logic [31:0] wdat;
  logic        we;

  logic [31:0] ledr_q;
  logic [31:0] ledg_q;
  logic [31:0] hexl_q;
  logic [31:0] hexh_q;
  logic [31:0] lcd_q;

  assign in_win = (i_lsu_addr[15:6] == 10'h1C0);
  assign word   = i_lsu_addr[5:2];
  assign off    = i_lsu_addr[1:0];
  assign we     = i_lsu_wren & in_win;

  // Misaligned halfword/word and size 11 leave be empty.
  always_comb begin
    be   = 4'b0000;
    wdat = 32'h0;
    unique case (i_st_size)
      2'b00: begin
        be   = 4'b0001 << off;
        wdat = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        if (!off[0]) be = off[1] ? 4'b1100 : 4'b0011;
        wdat = {2{i_st_data[15:0]}};
      end
      2'b10: begin
        if (off == 2'b00) be = 4'b1111;
        wdat = i_st_data;
      end
      default: be = 4'b0000;
    endcase
  end

  assign bm = {{8{be[3]}}, {8{be[2]}},
               {8{be[1]}}, {8{be[0]}}};

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [31:0] lanes,
    input logic [31:0] impl
  );
    return ((old & ~lanes) | (d & lanes)) & impl;
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ledr_q <= 32'h0;
      ledg_q <= 32'h0;
      hexl_q <= HEX_M;
      hexh_q <= HEX_M;
      lcd_q  <= 32'h0;
    end else if (we) begin
      unique case (1'b1)
        (word == 4'd0):
          ledr_q <= merge(ledr_q, wdat, bm, LEDR_M);
        (word == 4'd4):
          ledg_q <= merge(ledg_q, wdat, bm, LEDG_M);
        (word == 4'd8):
          hexl_q <= merge(hexl_q, wdat, bm, HEX_M);
        (word == 4'd9):
          hexh_q <= merge(hexh_q, wdat, bm, HEX_M);
        (word == 4'd12):
          lcd_q  <= merge(lcd_q, wdat, bm, LCD_M);
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ld_data = 32'h0;
    if (in_win) begin
      unique case (word)
        4'd0:    o_ld_data = ledr_q;
        4'd4:    o_ld_data = ledg_q;
        4'd8:    o_ld_data = hexl_q;
        4'd9:    o_ld_data = hexh_q;
        4'd12:   o_ld_data = lcd_q;
        default: o_ld_data = 32'h0;
      endcase
    end
  end

  assign o_io_ledr = ledr_q[LEDR_W-1:0];
  assign o_io_ledg = ledg_q[LEDG_W-1:0];
  assign o_io_lcd  = lcd_q[LCD_W-1:0];
  assign o_io_hex0 = hexl_q[6:0];
  assign o_io_hex1 = hexl_q[14:8];
  assign o_io_hex2 = hexl_q[22:16];
  assign o_io_hex3 = hexl_q[30:24];
  assign o_io_hex4 = hexh_q[6:0];
  assign o_io_hex5 = hexh_q[14:8];
  assign o_io_hex6 = hexh_q[22:16];
  assign o_io_hex7 = hexh_q[30:24];

endmodule

// File: tb/tb_lsu_output_buffer.sv
// Self-checking bench for lsu_output_buffer.
// Reference model is a 64-byte window image with per-byte masks.
module tb_lsu_output_buffer;

  localparam int LEDR_W = 17;
  localparam int LEDG_W = 8;
  localparam int LCD_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       addr;
  logic [31:0]       sdata;
  logic              wren;
  logic [1:0]        size;
  logic [31:0]       ld;
  logic [LEDR_W-1:0] ledr;
  logic [LEDG_W-1:0] ledg;
  logic [6:0]        hex [8];
  logic [LCD_W-1:0]  lcd;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] m [64];

  always #5 clk = ~clk;

  lsu_output_buffer #(
    .LEDR_W(LEDR_W),
    .LEDG_W(LEDG_W),
    .LCD_W (LCD_W)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_lsu_addr(addr),
    .i_st_data (sdata),
    .i_lsu_wren(wren),
    .i_st_size (size),
    .o_ld_data (ld),
    .o_io_ledr (ledr),
    .o_io_ledg (ledg),
    .o_io_hex0 (hex[0]),
    .o_io_hex1 (hex[1]),
    .o_io_hex2 (hex[2]),
    .o_io_hex3 (hex[3]),
    .o_io_hex4 (hex[4]),
    .o_io_hex5 (hex[5]),
    .o_io_hex6 (hex[6]),
    .o_io_hex7 (hex[7]),
    .o_io_lcd  (lcd)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bmask(input int a);
    int w, b, width;
    logic [7:0] mk;
    w = a / 4;
    b = a % 4;
    mk = 8'h00;
    case (w)
      0:       width = LEDR_W;
      4:       width = LEDG_W;
      12:      width = LCD_W;
      8, 9:    return 8'h7F;
      default: return 8'h00;
    endcase
    for (int i = 0; i < 8; i++)
      if (8 * b + i < width) mk[i] = 1'b1;
    return mk;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 64; i++)
      m[i] = (i >= 32 && i < 40) ? 8'h7F : 8'h00;
  endtask

  function automatic logic [31:0] mdl_word(input int w);
    return {m[4*w+3], m[4*w+2], m[4*w+1], m[4*w]};
  endfunction

  task automatic mdl_write(input logic [15:0] a,
                           input logic [31:0] d,
                           input logic [1:0]  sz);
    int o, nb, base;
    if (a[15:6] != 10'h1C0) return;
    o = int'(a[1:0]);
    case (sz)
      2'd0: nb = 1;
      2'd1: begin if (o % 2 != 0) return; nb = 2; end
      2'd2: begin if (o != 0) return; nb = 4; end
      default: return;
    endcase
    base = int'(a[5:0]);
    for (int k = 0; k < nb; k++)
      m[base+k] = d[8*k +: 8] & bmask(base + k);
  endtask

  task automatic check_pins();
    check("ledr", 32'(ledr), mdl_word(0));
    check("ledg", 32'(ledg), mdl_word(4));
    check("lcd", 32'(lcd), mdl_word(12));
    for (int n = 0; n < 8; n++)
      check($sformatf("hex%0d", n), 32'(hex[n]),
            32'(m[32+n][6:0]));
  endtask

  task automatic rd(input string tag,
                    input logic [15:0] a,
                    input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, ld, exp);
  endtask

  task automatic rd_mdl(input logic [15:0] a);
    if (a[15:6] == 10'h1C0)
      rd("rd_mdl", a, mdl_word(int'(a[5:2])));
  endtask

  task automatic op(input logic [15:0] a,
                    input logic [31:0] d,
                    input logic [1:0]  sz,
                    input logic        we);
    @(negedge clk);
    addr  = a;
    sdata = d;
    size  = sz;
    wren  = we;
    @(posedge clk);
    if (we) mdl_write(a, d, sz);
    #1;
    wren = 1'b0;
    check_pins();
  endtask

  initial begin
    logic [15:0] a;
    rst = 1'b1;
    addr = 16'h7000;
    sdata = 32'h0;
    wren = 1'b0;
    size = 2'd0;
    mdl_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_pins();
    rd("rst_hexlo", 16'h7020, 32'h7F7F7F7F);

    op(16'h7000, 32'hFFFFFFFF, 2'd2, 1'b1);
    check("ledr_all", 32'(ledr), 32'h0001FFFF);
    rd("rd_ledr", 16'h7000, 32'h0001FFFF);
    op(16'h7030, 32'h12345678, 2'd2, 1'b1);
    check("lcd_w", 32'(lcd), 32'h12345678);

    op(16'h7026, 32'h00000040, 2'd0, 1'b1);
    check("hex6_b", 32'(hex[6]), 32'h40);
    check("hex7_kept", 32'(hex[7]), 32'h7F);
    rd("rd_hexhi", 16'h7024, 32'h7F407F7F);
    op(16'h7020, 32'h000000C0, 2'd0, 1'b1);
    check("hex0_b7", 32'(hex[0]), 32'h40);

    op(16'h7012, 32'h0000ABCD, 2'd1, 1'b1);
    rd("rd_ledg_hi", 16'h7010, 32'h0);
    op(16'h7010, 32'h0000ABCD, 2'd1, 1'b1);
    check("ledg_h", 32'(ledg), 32'hCD);

    op(16'h7002, 32'hDEADBEEF, 2'd2, 1'b1);
    rd("mis_word", 16'h7000, 32'h0001FFFF);
    op(16'h7031, 32'hFFFFFFFF, 2'd1, 1'b1);
    rd("mis_half", 16'h7030, 32'h12345678);
    op(16'h7008, 32'hFFFFFFFF, 2'd2, 1'b1);
    rd("unmapped", 16'h7008, 32'h0);
    op(16'h7000, 32'h00000000, 2'd2, 1'b0);
    rd("no_wren", 16'h7000, 32'h0001FFFF);
    op(16'h7030, 32'hAAAAAAAA, 2'd3, 1'b1);
    rd("size11", 16'h7030, 32'h12345678);

    @(negedge clk);
    addr  = 16'h7010;
    sdata = 32'h55;
    size  = 2'd2;
    wren  = 1'b1;
    #1;
    check("ld_old", ld, 32'h000000CD);
    @(posedge clk);
    mdl_write(16'h7010, 32'h55, 2'd2);
    #1;
    wren = 1'b0;
    check("ld_new", ld, 32'h00000055);

    @(negedge clk);
    #2;
    rst = 1'b1;
    mdl_reset();
    #1;
    check_pins();
    rd("rst_async", 16'h7020, 32'h7F7F7F7F);
    rd("rst_lcd", 16'h7030, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    addr  = 16'h7000;
    sdata = 32'h0000ABCD;
    size  = 2'd2;
    wren  = 1'b1;
    #4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0;
    check("rst_edge", 32'(ledr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_pins();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = 16'($urandom_range(0, 16'hFFFF));
      else if ($urandom_range(0, 1) == 0)
        a = 16'h7000 | 16'($urandom_range(0, 63));
      else
        a = 16'h7000 | 16'(4 * (($urandom_range(0, 4) == 4)
              ? 12 : 4 * $urandom_range(0, 2)
              + $urandom_range(0, 1))
              + $urandom_range(0, 3));
      op(a, $urandom, 2'($urandom_range(0, 3)),
         $urandom_range(0, 4) != 0);
      rd_mdl(a);
      rd_mdl(16'h7000 | 16'($urandom_range(0, 63)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
